// File: rtl/i2s_transmitter_pkg.sv
// Shared frame geometry and slot packing for the I2S transmitter.
`include "constants.svh"

package i2s_transmitter_pkg;

   localparam int unsigned SLOT_BITS  = `I2S_SLOT_BITS;
   localparam int unsigned FRAME_BITS = `I2S_FRAME_BITS;
   localparam int unsigned BIT_CNT_W  = $clog2(FRAME_BITS);
   localparam logic [BIT_CNT_W-1:0] BIT_CNT_LAST = BIT_CNT_W'(FRAME_BITS - 1);

   // Each 32-bit slot: one leading zero (Philips one-BCLK delay), the sample
   // MSB first, then zero padding. Inputs arrive zero-extended to 31 bits.
   function automatic logic [FRAME_BITS-1:0] pack_frame(input logic [SLOT_BITS-2:0] left,
                                                        input logic [SLOT_BITS-2:0] right,
                                                        input int unsigned width);
      logic [FRAME_BITS-1:0] l_ext;
      logic [FRAME_BITS-1:0] r_ext;
      l_ext = FRAME_BITS'(left);
      r_ext = FRAME_BITS'(right);
      return (l_ext << (FRAME_BITS - 1 - width)) | (r_ext << (SLOT_BITS - 1 - width));
   endfunction

endpackage

// File: rtl/constants.svh
// Project-wide audio constants shared by the audio pipeline blocks.
`ifndef CONSTANTS_SVH
`define CONSTANTS_SVH

`define SAMPLE_RATE    48000
`define I2S_SLOT_BITS  32
`define I2S_FRAME_BITS 64

`endif

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider: toggles bclk every DIV system clocks and flags the
// cycle in which the bclk register goes high-to-low.
module i2s_bclk_gen #(
   parameter int unsigned DIV = 2
) (
   input  logic i_clk,
   input  logic i_rstn,
   input  logic i_enable,
   output logic o_bclk,
   output logic o_fall
);

   localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] r_div_cnt;
   logic             r_bclk;
   logic             w_wrap;

   assign w_wrap = i_enable && (r_div_cnt == CNT_LAST);
   assign o_fall = w_wrap && r_bclk;
   assign o_bclk = r_bclk;

   // Divider counter and bclk toggle; disable parks both at zero.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_div_cnt <= '0;
         r_bclk    <= 1'b0;
      end else if (!i_enable) begin
         r_div_cnt <= '0;
         r_bclk    <= 1'b0;
      end else if (w_wrap) begin
         r_div_cnt <= '0;
         r_bclk    <= ~r_bclk;
      end else begin
         r_div_cnt <= r_div_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/i2s_transmitter.sv
// I2S Philips-format stereo serialiser with a one-deep sample holding
// register and a per-frame sample strobe for upstream stages.
`include "constants.svh"

module i2s_transmitter
   import i2s_transmitter_pkg::*;
#(
   parameter int unsigned WIDTH       = 24,
   parameter int unsigned CLK_FRQ     = 12_288_000,
   parameter int unsigned SAMPLE_RATE = `SAMPLE_RATE
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    enable,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [WIDTH-1:0] in_left,
   input  logic signed [WIDTH-1:0] in_right,
   output logic                    bclk,
   output logic                    lrclk,
   output logic                    sdata,
   output logic                    sample_tick,
   output logic                    underrun
);

   localparam int unsigned DIV = CLK_FRQ / (2 * FRAME_BITS * SAMPLE_RATE);

   if (DIV < 1 || DIV * 2 * FRAME_BITS * SAMPLE_RATE != CLK_FRQ) begin : g_bad_div
      $error("i2s_transmitter: CLK_FRQ must be an exact multiple (>=1) of 128*SAMPLE_RATE");
   end
   if (WIDTH < 1 || WIDTH > SLOT_BITS - 1) begin : g_bad_width
      $error("i2s_transmitter: WIDTH must be in 1..31");
   end

   logic                  w_fall;
   logic                  w_bclk;
   logic                  w_load;
   logic                  w_accept;
   logic                  w_full_d;
   logic [BIT_CNT_W-1:0]  w_next_cnt;
   logic [WIDTH-1:0]      w_src_l;
   logic [WIDTH-1:0]      w_src_r;
   logic [FRAME_BITS-1:0] w_frame;

   logic                  r_full;
   logic                  r_in_ready;
   logic [WIDTH-1:0]      r_hold_l;
   logic [WIDTH-1:0]      r_hold_r;
   logic [BIT_CNT_W-1:0]  r_bit_cnt;
   logic [FRAME_BITS-1:0] r_shift;
   logic                  r_lrclk;
   logic                  r_sdata;
   logic                  r_tick;
   logic                  r_underrun;

   i2s_bclk_gen #(
      .DIV (DIV)
   ) u_bclk_gen (
      .i_clk    (clk),
      .i_rstn   (rstn),
      .i_enable (enable),
      .o_bclk   (w_bclk),
      .o_fall   (w_fall)
   );

   assign w_load     = w_fall && (r_bit_cnt == BIT_CNT_LAST);
   assign w_accept   = in_valid && r_in_ready;
   assign w_next_cnt = r_bit_cnt + 1'b1;

   // An empty holding register at load time sends silence rather than stale data.
   assign w_src_l = r_full ? r_hold_l : '0;
   assign w_src_r = r_full ? r_hold_r : '0;
   assign w_frame = pack_frame((SLOT_BITS - 1)'(w_src_l), (SLOT_BITS - 1)'(w_src_r), WIDTH);

   // Holding occupancy: a load drains it, an accept fills it (no bypass).
   always_comb begin
      w_full_d = r_full;
      if (w_load && r_full) w_full_d = 1'b0;
      if (w_accept)         w_full_d = 1'b1;
   end

   // Holding register and registered ready.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_full     <= 1'b0;
         r_in_ready <= 1'b0;
         r_hold_l   <= '0;
         r_hold_r   <= '0;
      end else begin
         r_full     <= w_full_d;
         r_in_ready <= ~w_full_d;
         if (w_accept) begin
            r_hold_l <= in_left;
            r_hold_r <= in_right;
         end
      end
   end

   // Serialiser: all outputs update on the bclk falling-edge cycle.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_bit_cnt  <= BIT_CNT_LAST;
         r_shift    <= '0;
         r_lrclk    <= 1'b0;
         r_sdata    <= 1'b0;
         r_tick     <= 1'b0;
         r_underrun <= 1'b0;
      end else if (!enable) begin
         r_bit_cnt  <= BIT_CNT_LAST;
         r_shift    <= '0;
         r_lrclk    <= 1'b0;
         r_sdata    <= 1'b0;
         r_tick     <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         r_tick     <= w_load;
         r_underrun <= w_load && !r_full;
         if (w_fall) begin
            r_bit_cnt <= w_next_cnt;
            r_lrclk   <= w_next_cnt[BIT_CNT_W-1];
            if (w_load) begin
               r_shift <= w_frame;
               r_sdata <= w_frame[FRAME_BITS-1];
            end else begin
               r_shift <= r_shift << 1;
               r_sdata <= r_shift[FRAME_BITS-2];
            end
         end
      end
   end

   assign in_ready    = r_in_ready;
   assign bclk        = w_bclk;
   assign lrclk       = r_lrclk;
   assign sdata       = r_sdata;
   assign sample_tick = r_tick;
   assign underrun    = r_underrun;

endmodule
